imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Parametrised, loadable instruction memory for the pipelined core's fetch stage. Replaces the fixed combinational program ROM with a synchronous-read RAM. The RAM is filled at boot through a sequential load port and then serves fetch requests with one-cycle latency, a stall hold and fault flagging. It sits between the PC register and the IF/ID pipeline register.

## Interface
- `DATA_W`, default 32: instruction width in bits.
- `DEPTH`, default 64: number of words; must be a power of two, at least 2.
- `ADDR_W`, default 32: byte-address width of `fetch_addr`.
- `NOP_WORD`, default 32'h00000013: word driven when no valid instruction is available.

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_start`  in  1  begins a program load at word 0.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_last`  in  1  qualifies the final `load_valid` beat.
- `load_data`  in  `DATA_W`  word to write.
- `load_busy`  out  1  high while in state LOAD.
- `load_err`  out  1  sticky flag: a beat was dropped because the load exceeded `DEPTH`.
- `fetch_req`  in  1  fetch request; address is sampled this cycle.
- `fetch_addr`  in  `ADDR_W`  byte address.
- `stall`  in  1  holds the fetch output.
- `instr`  out  `DATA_W`  fetched instruction.
- `instr_valid`  out  1  `instr` is valid.
- `fault`  out  1  qualifies `instr_valid`: the address was misaligned or out of range.

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE: fetches are ignored. Any `load_start` goes to LOAD.
- LOAD
  - On entry the word counter `wcnt` is 0 and `load_err` is cleared.
  - Each `load_valid` beat writes `mem[wcnt]` and increments `wcnt`.
  - If `wcnt` is at least `DEPTH`, the beat is dropped and `load_err` is set.
  - `load_valid && load_last` goes to RUN.
  - `load_start` during LOAD restarts: `wcnt` returns to 0 and `load_err` is cleared.
- RUN
  - `fetch_req && !stall`: index = `fetch_addr >> 2`. The address is bad if `fetch_addr[1:0]` is nonzero or the index is at least `DEPTH`.
  - Next cycle, good address: `instr` = `mem[index]`, `instr_valid`=1, `fault`=0.
  - Next cycle, bad address: `instr` = `NOP_WORD`, `instr_valid`=1, `fault`=1.
  - No request and no stall: `instr_valid`=0, `fault`=0, `instr` = `NOP_WORD`.
  - `stall`=1: `instr`, `instr_valid` and `fault` hold their values; `fetch_req` is ignored.
  - `load_start` in RUN returns to LOAD and beats the same-cycle `fetch_req`. `instr_valid` drops the next cycle.
- In IDLE and LOAD, `instr_valid`=0 and `instr` = `NOP_WORD`, regardless of `stall`.
- Memory contents are not reset. Reset in the middle of a load leaves the partial contents in place. `wcnt` returns to 0 and the FSM returns to IDLE.
- `wcnt` is `$clog2(DEPTH)+1` bits wide, so it saturates at `DEPTH` and does not wrap.

## Timing
- Reset values:
  - `instr` = `NOP_WORD`; `instr_valid`=0; `fault`=0.
  - `load_busy`=0; `load_err`=0.
  - FSM in IDLE; `wcnt`=0.
- Fetch latency: exactly 1 cycle, from the request edge to registered `instr`/`instr_valid`.
- Back-to-back requests give one result per cycle.
- Load writes commit on the edge of the beat. A `fetch_req` in the first RUN cycle reads the fully loaded data, so there is no read-during-write hazard.
- `load_busy` is registered. It goes high the cycle after `load_start` and low the cycle after the last beat.
- `stall` is sampled on the same edge as `fetch_req`. Releasing `stall` with `fetch_req`=1 issues that request, and its result appears 1 cycle later.

## Structure
- Package `imem_pkg` holds:
  - the `imem_state_t` enum (IDLE, LOAD, RUN);
  - the `NOP_WORD` default;
  - the default `DEPTH`/`DATA_W` localparams;
  - a `word_index()` function for the address-to-index conversion.
- Sub-module `imem_ram`: `DEPTH` × `DATA_W`, one write port, one synchronous read port with read enable; no reset on the array. It holds its output when read enable is low, which implements the stall hold.
- The FSM, counter, fault detection and output registers live in the top level.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → `instr`=32'h00000013, `instr_valid`=0, `load_busy`=0 immediately (asynchronous).
- **Load and fetch:**
  - Stimulus: load 9 words, 32'h02500193, 32'h02000513 … 32'h403502b3, with `load_last` on word 8; then fetch byte addresses 0, 4, 32 back-to-back.
  - Required: 32'h02500193, 32'h02000513, 32'h403502b3 on consecutive cycles, each 1 cycle after its request.
- **Faults:** fetch 0x2 → `fault`=1 with NOP; fetch `DEPTH*4` (256) → `fault`=1 with NOP; fetch 0x4 next → `fault`=0.
- **Stall:** request 0x0, then hold `stall`=1 for 3 cycles while requesting 0x4 → output stays 32'h02500193 with `instr_valid`=1; release → 32'h02000513 next cycle.
- **Overflow:** with `DEPTH`=4, load 6 beats → `load_err`=1, words 0–3 intact; then `load_start` → `load_err`=0.
- **Reload from RUN:** in RUN, `load_start` and `fetch_req` in the same cycle → no `instr_valid`, `load_busy`=1 the next cycle.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types, defaults and address helpers for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  localparam int          DATA_W_DEFAULT   = 32;
  localparam int          DEPTH_DEFAULT    = 64;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  // Wide enough that any realistic byte address converts without truncation.
  localparam int INDEX_W = 64;

  function automatic logic [INDEX_W-1:0] word_index(input logic [INDEX_W-1:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_ram.sv
// DEPTH x DATA_W array with one write port and one synchronous read port.
// The read register holds whenever rd_en is low; the array is never reset.
module imem_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write and registered read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= wdata;
    end
    if (rd_en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory for the fetch stage: loaded sequentially at boot, then
// serves one-cycle-latency fetches with stall hold and fault flagging.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter int                DEPTH    = DEPTH_DEFAULT,
  parameter int                ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_busy,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault
);

  localparam int                 AW       = $clog2(DEPTH);
  localparam int                 WC_W     = AW + 1;
  localparam logic [WC_W-1:0]    DEPTH_WC = WC_W'(DEPTH);
  localparam logic [INDEX_W-1:0] DEPTH_IX = INDEX_W'(DEPTH);

  imem_state_t        state_r, state_s;
  logic [WC_W-1:0]    wcnt_r, wcnt_s;
  logic               load_err_r, load_err_s;
  logic               load_busy_r;
  logic               valid_r, valid_s;
  logic               fault_r, fault_s;
  logic               write_s, issue_s, bad_s, rd_en_s;
  logic [INDEX_W-1:0] index_s;
  logic [DATA_W-1:0]  rdata_s;

  assign index_s  = word_index(INDEX_W'(fetch_addr));
  assign bad_s    = (fetch_addr[1:0] != 2'b00) || (index_s >= DEPTH_IX);
  assign rd_en_s  = issue_s && !bad_s;

  // Next-state, load counter and fetch-result flags.
  always_comb begin
    state_s    = state_r;
    wcnt_s     = wcnt_r;
    load_err_s = load_err_r;
    valid_s    = valid_r;
    fault_s    = fault_r;
    write_s    = 1'b0;
    issue_s    = 1'b0;
    case (state_r)
      IDLE: begin
        valid_s = 1'b0;
        fault_s = 1'b0;
        if (load_start) begin
          state_s    = LOAD;
          wcnt_s     = {WC_W{1'b0}};
          load_err_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        valid_s = 1'b0;
        fault_s = 1'b0;
        if (load_start) begin
          state_s    = LOAD;
          wcnt_s     = {WC_W{1'b0}};
          load_err_s = 1'b0;
        end else if (load_valid) begin
          // wcnt saturates at DEPTH; beats past the end are dropped and flagged.
          if (wcnt_r < DEPTH_WC) begin
            write_s = 1'b1;
            wcnt_s  = wcnt_r + WC_W'(1);
          end else begin
            load_err_s = 1'b1;
          end
          if (load_last) begin
            state_s = RUN;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      RUN: begin
        if (load_start) begin
          state_s    = LOAD;
          wcnt_s     = {WC_W{1'b0}};
          load_err_s = 1'b0;
          valid_s    = 1'b0;
          fault_s    = 1'b0;
        end else if (stall) begin
          valid_s = valid_r;
          fault_s = fault_r;
        end else if (fetch_req) begin
          issue_s = 1'b1;
          valid_s = 1'b1;
          fault_s = bad_s;
        end else begin
          valid_s = 1'b0;
          fault_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        fault_s = 1'b0;
      end
    endcase
  end

  // State, counter and output flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wcnt_r      <= {WC_W{1'b0}};
      load_err_r  <= 1'b0;
      load_busy_r <= 1'b0;
      valid_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      wcnt_r      <= wcnt_s;
      load_err_r  <= load_err_s;
      load_busy_r <= (state_s == LOAD);
      valid_r     <= valid_s;
      fault_r     <= fault_s;
    end
  end

  imem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .wr_en (write_s),
    .waddr (wcnt_r[AW-1:0]),
    .wdata (load_data),
    .rd_en (rd_en_s),
    .raddr (index_s[AW-1:0]),
    .rdata (rdata_s)
  );

  // The RAM read register holds through stalls; faults and idle cycles show NOP.
  assign instr       = (valid_r && !fault_r) ? rdata_s : NOP_WORD;
  assign instr_valid = valid_r;
  assign fault       = fault_r;
  assign load_busy   = load_busy_r;
  assign load_err    = load_err_r;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed self-checking bench: a default-depth unit for load/fetch/stall/fault
// behaviour and a DEPTH=4 unit for load overflow.
module tb_imem_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        load_start, load_valid, load_last, fetch_req, stall;
  logic [31:0] load_data, fetch_addr, instr;
  logic        load_busy, load_err, instr_valid, fault;

  logic        s_load_start, s_load_valid, s_load_last, s_fetch_req, s_stall;
  logic [31:0] s_load_data, s_fetch_addr, s_instr;
  logic        s_load_busy, s_load_err, s_instr_valid, s_fault;

  int          n_cmp;
  int          n_err;
  logic [31:0] prog [9];

  imem_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_data(load_data), .load_busy(load_busy), .load_err(load_err),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .fault(fault)
  );

  imem_fetch_unit #(.DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n),
    .load_start(s_load_start), .load_valid(s_load_valid), .load_last(s_load_last),
    .load_data(s_load_data), .load_busy(s_load_busy), .load_err(s_load_err),
    .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr), .stall(s_stall),
    .instr(s_instr), .instr_valid(s_instr_valid), .fault(s_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
    fetch_req = 1'b0; fetch_addr = 32'h0; stall = 1'b0;
    s_load_start = 1'b0; s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = 32'h0;
    s_fetch_req = 1'b0; s_fetch_addr = 32'h0; s_stall = 1'b0;
    prog[0] = 32'h0250_0193; prog[1] = 32'h0200_0513; prog[2] = 32'h00a0_0093;
    prog[3] = 32'h00b0_0113; prog[4] = 32'h00c0_0213; prog[5] = 32'h00d0_0313;
    prog[6] = 32'h00e0_0393; prog[7] = 32'h00f0_0413; prog[8] = 32'h4035_02b3;

    #3;
    chk("rst_instr", instr, NOP);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // IDLE ignores fetches
    fetch_req = 1'b1; fetch_addr = 32'd0;
    tick();
    chk("idle_valid", 32'(instr_valid), 32'd0);
    fetch_req = 1'b0;

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("busy_rise", 32'(load_busy), 32'd1);
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 8);
      tick();
      chk("load_no_valid", 32'(instr_valid), 32'd0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("busy_fall", 32'(load_busy), 32'd0);
    chk("load_err_clear", 32'(load_err), 32'd0);

    // back-to-back fetches, first one in the first RUN cycle
    fetch_req = 1'b1; fetch_addr = 32'd0;
    tick();
    chk("fetch0_instr", instr, 32'h0250_0193);
    chk("fetch0_valid", 32'(instr_valid), 32'd1);
    chk("fetch0_fault", 32'(fault), 32'd0);
    fetch_addr = 32'd4;
    tick();
    chk("fetch4_instr", instr, 32'h0200_0513);
    fetch_addr = 32'd32;
    tick();
    chk("fetch32_instr", instr, 32'h4035_02b3);
    fetch_req = 1'b0;
    tick();
    chk("noreq_valid", 32'(instr_valid), 32'd0);
    chk("noreq_instr", instr, NOP);

    // faults
    fetch_req = 1'b1; fetch_addr = 32'd2;
    tick();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(instr_valid), 32'd1);
    chk("mis_instr", instr, NOP);
    fetch_addr = 32'd256;
    tick();
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_instr", instr, NOP);
    fetch_addr = 32'd4;
    tick();
    chk("after_fault_fault", 32'(fault), 32'd0);
    chk("after_fault_instr", instr, 32'h0200_0513);

    // stall hold
    fetch_addr = 32'd0;
    tick();
    chk("pre_stall_instr", instr, 32'h0250_0193);
    fetch_addr = 32'd4; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, 32'h0250_0193);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("release_instr", instr, 32'h0200_0513);

    // reload from RUN beats a same-cycle fetch
    fetch_addr = 32'd0; load_start = 1'b1;
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    chk("reload_valid", 32'(instr_valid), 32'd0);
    chk("reload_busy", 32'(load_busy), 32'd1);
    load_valid = 1'b1; load_data = 32'hdead_beef;
    tick();
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(load_busy), 32'd0);
    chk("async_rst_instr", instr, NOP);
    tick();
    rst_n = 1'b1;
    tick();

    // memory survives reset; only word 0 is rewritten
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; load_data = 32'hcafe_0001;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    tick();
    chk("rewrite_w0", instr, 32'hcafe_0001);
    fetch_addr = 32'd4;
    tick();
    chk("kept_w1", instr, 32'h0200_0513);
    fetch_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(instr_valid), 32'd0);
    chk("async_rst_instr2", instr, NOP);
    tick();
    rst_n = 1'b1;
    tick();

    // overflow on the DEPTH=4 unit
    s_load_start = 1'b1;
    tick();
    s_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1'b1; s_load_data = 32'h1000_0000 + 32'(i); s_load_last = (i == 5);
      tick();
      if (i == 3) chk("ovf_err_at_full", 32'(s_load_err), 32'd0);
    end
    s_load_valid = 1'b0; s_load_last = 1'b0;
    chk("ovf_err", 32'(s_load_err), 32'd1);
    chk("ovf_busy", 32'(s_load_busy), 32'd0);
    s_fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_fetch_addr = 32'(i * 4);
      tick();
      chk("ovf_word", s_instr, 32'h1000_0000 + 32'(i));
      chk("ovf_word_fault", 32'(s_fault), 32'd0);
    end
    s_fetch_addr = 32'd16;
    tick();
    chk("small_oor_fault", 32'(s_fault), 32'd1);
    chk("small_oor_instr", s_instr, NOP);
    s_fetch_req = 1'b0; s_load_start = 1'b1;
    tick();
    s_load_start = 1'b0;
    chk("ovf_err_cleared", 32'(s_load_err), 32'd0);
    chk("small_reload_busy", 32'(s_load_busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
